ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 250000, SHALL be the idle cycles after which a partial prefix sequence is discarded (5 ms at 50 MHz).
REQ-002 CLOCK_50  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-003 RST  input  1  SHALL be the asynchronous, active-low reset (0 = reset).
REQ-004 scan_code  input  8  SHALL be the PS/2 set-2 byte from the keyboard receiver, sampled only when scan_valid=1.
REQ-005 scan_valid  input  1  SHALL be a one-cycle strobe per received byte (the oneshot read pulse).
REQ-006 ev_valid  output  1  SHALL be a one-cycle strobe marking a completed key event.
REQ-007 ev_code  output  8  SHALL be the final (non-prefix) byte of the event.
REQ-008 ev_ext  output  1  SHALL be 1 if the event carried an E0 prefix.
REQ-009 ev_break  output  1  SHALL be 1 for release (F0 prefix), 0 for press.
REQ-010 ev_repeat  output  1  SHALL be 1 for a press of a note key already held (typematic repeat).
REQ-011 held_mask  output  13  SHALL have bit i = 1 while note key i is held.
REQ-012 note_on  output  1  SHALL be 1 whenever held_mask is nonzero.
REQ-013 note_idx  output  4  SHALL be the current sounding semitone 0..12.

Function
REQ-014 Note keys (non-extended make codes) SHALL map: 1C->0, 1D->1, 1B->2, 24->3, 23->4, 2B->5, 2C->6, 34->7, 35->8, 33->9, 3C->10, 3B->11, 42->12; all other codes are non-note.
REQ-015 FSM states SHALL be IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP_E1.
REQ-016 IDLE: E0->GOT_E0; F0->GOT_F0; E1->SKIP_E1 with skip counter=7; any other byte -> emit press event, stay IDLE.
REQ-017 GOT_E0: F0->GOT_E0F0; E0 stays GOT_E0; other byte -> emit extended press, IDLE.
REQ-018 GOT_F0: other byte -> emit release, IDLE; GOT_E0F0: other byte -> emit extended release, IDLE; F0/E0 in these states SHALL be ignored (state held).
REQ-019 SKIP_E1: each byte decrements counter; return to IDLE after the 7th byte, no event emitted.
REQ-020 Bytes AA, FA, FE, EE, 00, FF received in IDLE SHALL be discarded with no event.
REQ-021 ev_valid and all ev_* fields SHALL be registered, asserting exactly one cycle after the scan_valid of the final byte; ev_* fields hold their last value otherwise.
REQ-022 held_mask, note_on, note_idx SHALL update in the same cycle ev_valid asserts.
REQ-023 Extended events SHALL NOT affect held_mask or note_idx.
REQ-024 Press of unheld note key i: set bit i, note_idx=i, ev_repeat=0.
REQ-025 Press of held note key i: ev_repeat=1, held_mask and note_idx unchanged.
REQ-026 Release of key i where i==note_idx: clear bit i; if others remain held, note_idx = lowest held index; else note_idx unchanged and note_on=0.
REQ-027 Release of key i != note_idx, or of an unheld key: clear bit i (no-op if clear), note_idx unchanged.
REQ-028 An idle counter SHALL reset on each scan_valid; in any non-IDLE state, reaching TIMEOUT_CYCLES forces IDLE and clears skip counter, no event.
REQ-029 scan_valid in the same cycle as timeout expiry SHALL be decoded from IDLE.
REQ-030 scan_valid in the cycle ev_valid is high SHALL be accepted; back-to-back bytes on consecutive cycles SHALL be handled without loss.

Reset
REQ-031 RST=0 SHALL immediately force state IDLE, counters 0, ev_valid=0, ev_code=00, ev_ext=0, ev_break=0, ev_repeat=0, held_mask=0, note_on=0, note_idx=0, regardless of sequence in progress.
REQ-032 After RST deassertion, the first byte SHALL be decoded from IDLE.

Verification
REQ-033 Bytes 1C, F0 1C -> press ev(1C,ext0,brk0), held_mask=0x0001, note_idx=0; then release ev, held_mask=0, note_on=0.
REQ-034 Press 1C, press 42, release 42 -> note_idx 0, 12, then 0; held_mask 0x1001 then 0x0001.
REQ-035 E0 75, E0 F0 75 -> ev_ext=1 press then release; held_mask stays 0.
REQ-036 E1 14 77 E1 F0 14 F0 77 -> no ev_valid; next byte 1D produces press, note_idx=1.
REQ-037 F0, wait TIMEOUT_CYCLES+1, 1C -> press (ev_break=0); 1C repeated -> ev_repeat=1; RST pulse mid "E0 F0" -> all outputs zero, next 1B decoded as press.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Turns the PS/2 set-2 byte stream from a keyboard receiver into key
//   events. It also tracks which of the 13 note keys are held and which
//   semitone is currently sounding.
//
//   Ports
//     CLOCK_50    in   system clock, rising edge
//     RST         in   asynchronous reset, active low
//     scan_code   in   [7:0] received byte, valid with scan_valid
//     scan_valid  in   one-cycle strobe per received byte
//     ev_valid    out  one-cycle strobe per completed key event
//     ev_code     out  [7:0] final, non-prefix byte of the event
//     ev_ext      out  event carried an E0 prefix
//     ev_break    out  release event (F0 prefix)
//     ev_repeat   out  typematic press of a note key that is already held
//     held_mask   out  [12:0] bit i set while note key i is held
//     note_on     out  any note key held
//     note_idx    out  [3:0] sounding semitone 0..12
//
//   state     | meaning
//   ----------+------------------------------------------------
//   IDLE      | waiting for a prefix or a make code
//   GOT_E0    | E0 seen, the next byte is extended
//   GOT_F0    | F0 seen, the next byte is a release
//   GOT_E0F0  | E0 F0 seen, the next byte is an extended release
//   SKIP_E1   | swallowing the 7 bytes that follow E1 (Pause key)

module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic        CLOCK_50,
    input  logic        RST,
    input  logic [7:0]  scan_code,
    input  logic        scan_valid,
    output logic        ev_valid,
    output logic [7:0]  ev_code,
    output logic        ev_ext,
    output logic        ev_break,
    output logic        ev_repeat,
    output logic [12:0] held_mask,
    output logic        note_on,
    output logic [3:0]  note_idx
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0,
        SKIP_E1
    } state_t;

    state_t      state_q, state_d, state_cur;
    logic [2:0]  skip_cnt_q, skip_cnt_d, skip_cur;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic        ev_valid_q, ev_valid_d;
    logic [7:0]  ev_code_q, ev_code_d;
    logic        ev_ext_q, ev_ext_d;
    logic        ev_break_q, ev_break_d;
    logic        ev_repeat_q, ev_repeat_d;
    logic [12:0] held_mask_q, held_mask_d;
    logic        note_on_q, note_on_d;
    logic [3:0]  note_idx_q, note_idx_d;

    logic        timeout_hit;
    logic        emit, emit_ext, emit_brk;
    logic        note_hit;
    logic [3:0]  note_num;

    // {hit, semitone} for a non-extended code
    function automatic logic [4:0] note_lookup(input logic [7:0] code);
        logic [4:0] r;
        case (code)
            8'h1C:   r = {1'b1, 4'd0};
            8'h1D:   r = {1'b1, 4'd1};
            8'h1B:   r = {1'b1, 4'd2};
            8'h24:   r = {1'b1, 4'd3};
            8'h23:   r = {1'b1, 4'd4};
            8'h2B:   r = {1'b1, 4'd5};
            8'h2C:   r = {1'b1, 4'd6};
            8'h34:   r = {1'b1, 4'd7};
            8'h35:   r = {1'b1, 4'd8};
            8'h33:   r = {1'b1, 4'd9};
            8'h3C:   r = {1'b1, 4'd10};
            8'h3B:   r = {1'b1, 4'd11};
            8'h42:   r = {1'b1, 4'd12};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lowest_held(input logic [12:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 12; i >= 0; i--) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Receiver status bytes that never start a key sequence
    function automatic logic is_discard(input logic [7:0] code);
        return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hFE) ||
               (code == 8'hEE) || (code == 8'h00) || (code == 8'hFF);
    endfunction

    always_comb begin
        // An expiring timeout acts in the same cycle, so a byte arriving
        // right then is decoded from IDLE.
        timeout_hit = (state_q != IDLE) && (idle_cnt_q == '0);
        state_cur   = timeout_hit ? IDLE : state_q;
        skip_cur    = timeout_hit ? 3'd0 : skip_cnt_q;

        state_d     = state_cur;
        skip_cnt_d  = skip_cur;
        idle_cnt_d  = (idle_cnt_q != '0) ? idle_cnt_q - CNT_W'(1) : idle_cnt_q;
        ev_valid_d  = 1'b0;
        ev_code_d   = ev_code_q;
        ev_ext_d    = ev_ext_q;
        ev_break_d  = ev_break_q;
        ev_repeat_d = ev_repeat_q;
        held_mask_d = held_mask_q;
        note_idx_d  = note_idx_q;
        emit        = 1'b0;
        emit_ext    = 1'b0;
        emit_brk    = 1'b0;
        {note_hit, note_num} = note_lookup(scan_code);

        if (scan_valid) begin
            idle_cnt_d = CNT_LOAD;
            case (state_cur)
                IDLE: begin
                    if (scan_code == 8'hE0) begin
                        state_d = GOT_E0;
                    end else if (scan_code == 8'hF0) begin
                        state_d = GOT_F0;
                    end else if (scan_code == 8'hE1) begin
                        state_d    = SKIP_E1;
                        skip_cnt_d = 3'd7;
                    end else if (!is_discard(scan_code)) begin
                        emit = 1'b1;
                    end
                end
                GOT_E0: begin
                    if (scan_code == 8'hF0) begin
                        state_d = GOT_E0F0;
                    end else if (scan_code != 8'hE0) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = IDLE;
                    end
                end
                GOT_F0: begin
                    if (scan_code != 8'hF0 && scan_code != 8'hE0) begin
                        emit     = 1'b1;
                        emit_brk = 1'b1;
                        state_d  = IDLE;
                    end
                end
                GOT_E0F0: begin
                    if (scan_code != 8'hF0 && scan_code != 8'hE0) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        emit_brk = 1'b1;
                        state_d  = IDLE;
                    end
                end
                SKIP_E1: begin
                    if (skip_cur <= 3'd1) begin
                        skip_cnt_d = 3'd0;
                        state_d    = IDLE;
                    end else begin
                        skip_cnt_d = skip_cur - 3'd1;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    skip_cnt_d = 3'd0;
                end
            endcase
        end

        if (emit) begin
            ev_valid_d  = 1'b1;
            ev_code_d   = scan_code;
            ev_ext_d    = emit_ext;
            ev_break_d  = emit_brk;
            ev_repeat_d = 1'b0;
            if (note_hit && !emit_ext) begin
                if (!emit_brk) begin
                    if (held_mask_q[note_num]) begin
                        ev_repeat_d = 1'b1;
                    end else begin
                        held_mask_d[note_num] = 1'b1;
                        note_idx_d            = note_num;
                    end
                end else begin
                    held_mask_d[note_num] = 1'b0;
                    // Falling back to the lowest held key only when the
                    // sounding one is let go; with nothing left the last
                    // pitch is kept and note_on drops.
                    if (note_num == note_idx_q && held_mask_d != 13'd0) begin
                        note_idx_d = lowest_held(held_mask_d);
                    end
                end
            end
        end

        note_on_d = (held_mask_d != 13'd0);
    end

    always_ff @(posedge CLOCK_50 or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            skip_cnt_q  <= 3'd0;
            idle_cnt_q  <= '0;
            ev_valid_q  <= 1'b0;
            ev_code_q   <= 8'h00;
            ev_ext_q    <= 1'b0;
            ev_break_q  <= 1'b0;
            ev_repeat_q <= 1'b0;
            held_mask_q <= 13'd0;
            note_on_q   <= 1'b0;
            note_idx_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            ev_valid_q  <= ev_valid_d;
            ev_code_q   <= ev_code_d;
            ev_ext_q    <= ev_ext_d;
            ev_break_q  <= ev_break_d;
            ev_repeat_q <= ev_repeat_d;
            held_mask_q <= held_mask_d;
            note_on_q   <= note_on_d;
            note_idx_q  <= note_idx_d;
        end
    end

    assign ev_valid  = ev_valid_q;
    assign ev_code   = ev_code_q;
    assign ev_ext    = ev_ext_q;
    assign ev_break  = ev_break_q;
    assign ev_repeat = ev_repeat_q;
    assign held_mask = held_mask_q;
    assign note_on   = note_on_q;
    assign note_idx  = note_idx_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench for ps2_key_decoder: expected events are queued as bytes are
// driven and compared when ev_valid fires.
module tb_ps2_key_decoder;

    localparam int TMO = 20;

    logic        CLOCK_50 = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  scan_code = 8'h00;
    logic        scan_valid = 1'b0;
    logic        ev_valid;
    logic [7:0]  ev_code;
    logic        ev_ext;
    logic        ev_break;
    logic        ev_repeat;
    logic [12:0] held_mask;
    logic        note_on;
    logic [3:0]  note_idx;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK_50   (CLOCK_50),
        .RST        (RST),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .ev_valid   (ev_valid),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_break   (ev_break),
        .ev_repeat  (ev_repeat),
        .held_mask  (held_mask),
        .note_on    (note_on),
        .note_idx   (note_idx)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [7:0]  code;
        logic        ext;
        logic        brk;
        logic        rep;
        logic [12:0] held;
        logic        on;
        logic [3:0]  idx;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    logic sv_at_edge = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic expect_ev(input logic [7:0] c, input logic x, input logic b,
                             input logic r, input logic [12:0] h, input logic [3:0] i);
        exp_t e;
        e.code = c; e.ext = x; e.brk = b; e.rep = r;
        e.held = h; e.on = (h != 13'd0); e.idx = i;
        sb_q.push_back(e);
    endtask

    // Called just after a rising edge; leaves the bench just after the
    // edge that sampled the byte, so consecutive calls are back-to-back.
    task automatic send(input logic [7:0] b);
        scan_code  = b;
        scan_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        scan_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    always @(posedge CLOCK_50) sv_at_edge <= scan_valid;

    always @(negedge CLOCK_50) begin
        if (RST && ev_valid) begin
            exp_t e;
            check("ev_pending", {31'd0, sb_q.size() != 0}, 32'd1);
            check("ev_timing", {31'd0, sv_at_edge}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("ev_fields", {21'd0, ev_code, ev_ext, ev_break, ev_repeat},
                      {21'd0, e.code, e.ext, e.brk, e.rep});
                check("note_state", {14'd0, held_mask, note_on, note_idx},
                      {14'd0, e.held, e.on, e.idx});
            end
        end
    end

    task automatic check_zero(input string tag);
        check(tag, {4'd0, ev_valid, ev_code, ev_ext, ev_break, ev_repeat,
                    held_mask, note_on, note_idx}, 32'd0);
    endtask

    initial begin
        idle(3);
        check_zero("reset_outputs");
        RST = 1'b1;
        idle(2);

        // press and release of the lowest note
        expect_ev(8'h1C, 0, 0, 0, 13'h0001, 4'd0);
        send(8'h1C);
        idle(2);
        expect_ev(8'h1C, 0, 1, 0, 13'h0000, 4'd0);
        send(8'hF0); send(8'h1C);
        idle(3);

        // two notes, release the sounding one
        expect_ev(8'h1C, 0, 0, 0, 13'h0001, 4'd0);
        expect_ev(8'h42, 0, 0, 0, 13'h1001, 4'd12);
        expect_ev(8'h42, 0, 1, 0, 13'h0001, 4'd0);
        expect_ev(8'h1C, 0, 1, 0, 13'h0000, 4'd0);
        send(8'h1C); idle(1);
        send(8'h42); idle(1);
        send(8'hF0); send(8'h42); idle(1);
        send(8'hF0); send(8'h1C);
        idle(3);

        // back-to-back burst, release of a non-sounding key
        expect_ev(8'h1C, 0, 0, 0, 13'h0001, 4'd0);
        expect_ev(8'h1B, 0, 0, 0, 13'h0005, 4'd2);
        expect_ev(8'h24, 0, 0, 0, 13'h000D, 4'd3);
        expect_ev(8'h1B, 0, 1, 0, 13'h0009, 4'd3);
        expect_ev(8'h24, 0, 1, 0, 13'h0001, 4'd0);
        expect_ev(8'h1C, 0, 1, 0, 13'h0000, 4'd0);
        send(8'h1C); send(8'h1B); send(8'h24);
        send(8'hF0); send(8'h1B); send(8'hF0); send(8'h24);
        send(8'hF0); send(8'h1C);
        idle(3);

        // extended events leave the note state alone
        expect_ev(8'h75, 1, 0, 0, 13'h0000, 4'd0);
        expect_ev(8'h75, 1, 1, 0, 13'h0000, 4'd0);
        expect_ev(8'h1C, 1, 0, 0, 13'h0000, 4'd0);
        send(8'hE0); send(8'h75); idle(1);
        send(8'hE0); send(8'hF0); send(8'h75); idle(1);
        send(8'hE0); send(8'hE0); send(8'h1C);
        idle(3);

        // Pause sequence is swallowed, then decoding resumes
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        idle(2);
        expect_ev(8'h1D, 0, 0, 0, 13'h0002, 4'd1);
        expect_ev(8'h1D, 0, 1, 0, 13'h0000, 4'd1);
        send(8'h1D); idle(1);
        send(8'hF0); send(8'h1D);
        idle(3);

        // status bytes dropped; non-note keys never repeat
        send(8'hAA); send(8'hFA); send(8'h00);
        expect_ev(8'h5A, 0, 0, 0, 13'h0000, 4'd1);
        expect_ev(8'h5A, 0, 0, 0, 13'h0000, 4'd1);
        send(8'h5A); send(8'h5A);
        idle(3);

        // stale F0 expires; repeat of a held note
        send(8'hF0);
        idle(TMO + 1);
        expect_ev(8'h1C, 0, 0, 0, 13'h0001, 4'd0);
        expect_ev(8'h1C, 0, 0, 1, 13'h0001, 4'd0);
        send(8'h1C); idle(1);
        send(8'h1C); idle(1);
        // F0 still live just short of the timeout
        send(8'hF0);
        idle(TMO - 2);
        expect_ev(8'h1C, 0, 1, 0, 13'h0000, 4'd0);
        send(8'h1C);
        idle(3);

        // stale E0 and a half-skipped Pause both expire
        send(8'hE0);
        idle(TMO + 1);
        expect_ev(8'h75, 0, 0, 0, 13'h0000, 4'd0);
        send(8'h75);
        send(8'hE1); send(8'h14);
        idle(TMO + 1);
        expect_ev(8'h1D, 0, 0, 0, 13'h0002, 4'd1);
        send(8'h1D);
        idle(3);

        // reset in the middle of E0 F0 with a note held
        expect_ev(8'h1C, 0, 0, 0, 13'h0003, 4'd0);
        send(8'h1C); idle(1);
        send(8'hE0); send(8'hF0);
        RST = 1'b0;
        #1;
        check_zero("mid_reset_outputs");
        idle(1);
        RST = 1'b1;
        idle(2);
        expect_ev(8'h1B, 0, 0, 0, 13'h0004, 4'd2);
        send(8'h1B);
        idle(5);

        check("sb_drain", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
